btn_queue: RTL



---
 rtl/btn_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/btn_queue.sv
// Button front end: 2-FF synchronizer, per-button debounce, press detection
// and a small first-word-fall-through queue of button codes for the CPU.
module btn_queue #(
  parameter int DB_CYCLES = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             btn,
  input  logic                   rd,
  input  logic                   clr_ovf,
  output logic                   valid,
  output logic [2:0]             code,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int CW   = $clog2(DB_CYCLES);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [4:0]    s1, s2, stable, rise, pending, sel_mask;
  logic [CW-1:0] db_cnt [5];
  logic [2:0]    sel_idx;
  logic          have_sel, full, pop, push, drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    mem [DEPTH];

  // A press is a debounced 0->1 flip; it lands in pending on the flip edge.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      rise[i] = s2[i] && !stable[i] && (db_cnt[i] == CW'(DB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index pending press wins; the downward scan leaves it last-written.
  always_comb begin
    sel_idx  = '0;
    have_sel = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx  = 3'(i);
        have_sel = 1'b1;
      end
    end
    sel_mask = have_sel ? (5'b00001 << sel_idx) : 5'b00000;
  end

  assign full  = (count == CNTW'(DEPTH));
  assign valid = (count != '0);
  assign pop   = rd && valid;
  assign push  = have_sel && (!full || pop);
  assign drop  = have_sel && full && !pop;
  assign code  = valid ? mem[rd_ptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~sel_mask) | rise;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as clr_ovf must still leave the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule
